sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter_pkg.sv | 23 ++
 rtl/sram_port_arbiter_rr_arbiter.sv | 48 ++++
 rtl/sram_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: FSM states, nibble bus width and
// the SRAM operation encodings driven onto the oe/we pins.
package sram_port_arbiter_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_WR_LO   = 3'd2,
        ST_WR_HI   = 3'd3,
        ST_WR_ADDR = 3'd4,
        ST_RD_ADDR = 3'd5,
        ST_RD_CAP  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2
    } sram_op_t;

endpackage

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// Round-robin selector: one-hot grant from a request vector, searching from
// the index after the last granted one; the pointer moves only on i_adv.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_adv,
    output logic [NREQ-1:0] o_gnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] r_last;
    logic [IW-1:0] w_idx;
    logic          w_found;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int step);
        int s;
        s = int'(base) + step;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    always_comb begin
        o_gnt   = '0;
        w_idx   = r_last;
        w_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && i_req[wrap_idx(r_last, k)]) begin
                w_found = 1'b1;
                w_idx   = wrap_idx(r_last, k);
            end
        end
        if (w_found) o_gnt[w_idx] = 1'b1;
    end

    // Reset to the last index so requester 0 wins the first search.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= IW'(NREQ - 1);
        end else if (i_adv && w_found) begin
            r_last <= w_idx;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates NREQ requesters onto a single nibble-serial SRAM port: writes go
// out as lo/hi data nibbles then the address, reads as a two-cycle address phase.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = 3,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rdata,
    output logic [NIB_W-1:0]   sram_ad,
    output logic               sram_oe,
    output logic               sram_we,
    output logic               sram_rst,
    input  logic [DW-1:0]      sram_dout
);

    state_t             r_state;
    state_t             w_next;
    sram_op_t           w_op;

    logic [NREQ-1:0]    r_gnt;
    logic [NREQ-1:0]    r_done;
    logic [DW-1:0]      r_rdata;
    logic [AW-1:0]      r_addr;
    logic [DW-1:0]      r_wdata;

    logic [NREQ-1:0]    w_req_eff;
    logic [NREQ-1:0]    w_gnt;
    logic               w_grant;
    logic               w_sel_we;
    logic [AW-1:0]      w_sel_addr;
    logic [DW-1:0]      w_sel_wdata;
    logic [NIB_W-1:0]   w_addr_nib;

    // A requester seeing its done pulse may still hold req this cycle; mask it
    // so the same operation is not granted a second time.
    assign w_req_eff = req & ~r_done;
    assign w_grant   = (r_state == ST_IDLE) && (|w_req_eff);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk   (clk),
        .rst   (rst),
        .i_req (w_req_eff),
        .i_adv (w_grant),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_we    = we[i];
                w_sel_addr  = addr[i*AW +: AW];
                w_sel_wdata = wdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT:    w_next = ST_IDLE;
            ST_IDLE: begin
                if (w_grant) w_next = w_sel_we ? ST_WR_LO : ST_RD_ADDR;
            end
            ST_WR_LO:   w_next = ST_WR_HI;
            ST_WR_HI:   w_next = ST_WR_ADDR;
            ST_WR_ADDR: w_next = ST_IDLE;
            ST_RD_ADDR: w_next = ST_RD_CAP;
            ST_RD_CAP:  w_next = ST_IDLE;
            default:    w_next = ST_INIT;
        endcase
    end

    // Operation fields are frozen at grant; later requester changes are ignored.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt <= '0;
        end else if (w_grant) begin
            r_gnt <= w_gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= '0;
        end else if (r_state == ST_WR_ADDR || r_state == ST_RD_CAP) begin
            r_done <= r_gnt;
        end else begin
            r_done <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (r_state == ST_RD_CAP) begin
            r_rdata <= sram_dout;
        end
    end

    assign w_addr_nib = NIB_W'(r_addr);

    always_comb begin
        w_op     = OP_IDLE;
        sram_ad  = '0;
        sram_rst = 1'b0;
        case (r_state)
            ST_INIT:    sram_rst = 1'b1;
            ST_WR_LO: begin
                w_op    = OP_WRITE;
                sram_ad = r_wdata[NIB_W-1:0];
            end
            ST_WR_HI: begin
                w_op    = OP_WRITE;
                sram_ad = r_wdata[2*NIB_W-1:NIB_W];
            end
            ST_WR_ADDR: begin
                w_op    = OP_WRITE;
                sram_ad = w_addr_nib;
            end
            ST_RD_ADDR, ST_RD_CAP: begin
                w_op    = OP_READ;
                sram_ad = w_addr_nib;
            end
            default: begin
                w_op    = OP_IDLE;
                sram_ad = '0;
            end
        endcase
    end

    assign sram_we = (w_op == OP_WRITE);
    assign sram_oe = (w_op == OP_READ);
    assign done    = r_done;
    assign rdata   = r_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter with a nibble-serial SRAM model and a
// scoreboard of expected completions checked on every done pulse.
module tb_sram_port_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 3;
    localparam int DW   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    done;
    logic [DW-1:0]      rdata;
    logic [3:0]         sram_ad;
    logic               sram_oe;
    logic               sram_we;
    logic               sram_rst;
    logic [DW-1:0]      sram_dout;

    int n_cmp  = 0;
    int n_fail = 0;

    sram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .done      (done),
        .rdata     (rdata),
        .sram_ad   (sram_ad),
        .sram_oe   (sram_oe),
        .sram_we   (sram_we),
        .sram_rst  (sram_rst),
        .sram_dout (sram_dout)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // SRAM model: collects lo nibble, hi nibble, address; sram_rst discards a partial sequence.
    logic [DW-1:0] mem [0:7] = '{default: '0};
    logic [1:0]    nib_cnt = 2'd0;
    logic [3:0]    nib_lo  = 4'd0;
    logic [3:0]    nib_hi  = 4'd0;

    always @(posedge clk) begin
        if (sram_rst) begin
            nib_cnt <= 2'd0;
        end else if (sram_we) begin
            case (nib_cnt)
                2'd0: begin nib_lo <= sram_ad; nib_cnt <= 2'd1; end
                2'd1: begin nib_hi <= sram_ad; nib_cnt <= 2'd2; end
                default: begin mem[sram_ad[2:0]] <= {nib_hi, nib_lo}; nib_cnt <= 2'd0; end
            endcase
        end
    end

    assign sram_dout = sram_oe ? mem[sram_ad[2:0]] : 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int            idx;
        logic          is_wr;
        logic [DW-1:0] rd;
    } exp_t;

    exp_t          sb[$];
    exp_t          sb_e;
    logic [DW-1:0] last_rd = '0;

    always @(negedge clk) begin
        if (rst) last_rd = '0;
        if (|done) begin
            check("done_onehot", 32'($countones(done)), 32'd1);
            if (sb.size() == 0) begin
                check("done_unexpected", 32'(done), 32'd0);
            end else begin
                sb_e = sb.pop_front();
                check("done_idx", 32'(done), 32'(1 << sb_e.idx));
                if (sb_e.is_wr) begin
                    check("rdata_hold", 32'(rdata), 32'(last_rd));
                end else begin
                    check("rdata", 32'(rdata), 32'(sb_e.rd));
                    last_rd = sb_e.rd;
                end
            end
        end
    end

    logic [3:0] tr_ad [0:15];
    logic       tr_we [0:15];
    logic       tr_oe [0:15];
    int         lat;
    int         ndone;

    task automatic wait_done(input int idx);
        lat = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            tr_ad[k] = sram_ad;
            tr_we[k] = sram_we;
            tr_oe[k] = sram_oe;
            if (done[idx]) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            check("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    task automatic run_op(input int idx, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
        exp_t e;
        @(posedge clk); #1;
        req[idx]            = 1'b1;
        we[idx]             = w;
        addr[idx*AW +: AW]  = a;
        wdata[idx*DW +: DW] = d;
        e.idx   = idx;
        e.is_wr = w;
        e.rd    = exp_rd;
        sb.push_back(e);
        wait_done(idx);
        req[idx] = 1'b0;
    endtask

    task automatic check_trace(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        check("idle_bus", 32'({tr_we[0], tr_oe[0], tr_ad[0]}), 32'd0);
        if (w) begin
            check("wr_lat", 32'(lat), 32'd4);
            check("wr_lo_nib", 32'(tr_ad[1]), 32'(d[3:0]));
            check("wr_hi_nib", 32'(tr_ad[2]), 32'(d[7:4]));
            check("wr_addr_nib", 32'(tr_ad[3]), 32'(a));
            for (int k = 1; k <= 3; k++) check("wr_we_oe", 32'({tr_we[k], tr_oe[k]}), 32'b10);
        end else begin
            check("rd_lat", 32'(lat), 32'd3);
            for (int k = 1; k <= 2; k++) begin
                check("rd_addr_nib", 32'(tr_ad[k]), 32'(a));
                check("rd_we_oe", 32'({tr_we[k], tr_oe[k]}), 32'b01);
            end
        end
    endtask

    typedef struct {
        int            idx;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t tbl [16];

    initial begin
        for (int i = 0; i < 8; i++) begin
            tbl[i].idx      = i % 2;
            tbl[i].w        = 1'b1;
            tbl[i].a        = AW'(i);
            tbl[i].d        = DW'(i * 17);
            tbl[i].exp_rd   = '0;
            tbl[8+i].idx    = i % 2;
            tbl[8+i].w      = 1'b0;
            tbl[8+i].a      = AW'(i);
            tbl[8+i].d      = '0;
            tbl[8+i].exp_rd = DW'(i * 17);
        end

        // Reset state.
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_bus", 32'({sram_oe, sram_we, sram_ad}), 32'd0);
        check("rst_sram_rst", 32'(sram_rst), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("init_sram_rst", 32'(sram_rst), 32'd1);
        @(negedge clk);
        check("idle_sram_rst", 32'(sram_rst), 32'd0);

        // Basic write then read from the other requester.
        run_op(0, 1'b1, 3'd5, 8'hA7, 8'h00);
        check_trace(1'b1, 3'd5, 8'hA7);
        run_op(1, 1'b0, 3'd5, 8'h00, 8'hA7);
        check_trace(1'b0, 3'd5, 8'h00);

        // Fill all addresses with addr*0x11 and read back.
        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i].idx, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp_rd);
            check_trace(tbl[i].w, tbl[i].a, tbl[i].d);
        end

        // Both requesters held continuously: grants alternate starting at 0.
        @(posedge clk); #1;
        req = 2'b11; we = 2'b01; addr = {3'd6, 3'd6}; wdata = {8'h00, 8'h5A};
        sb.push_back('{0, 1'b1, 8'h00});
        sb.push_back('{1, 1'b0, 8'h5A});
        sb.push_back('{0, 1'b1, 8'h00});
        sb.push_back('{1, 1'b0, 8'h5A});
        ndone = 0;
        for (int k = 0; k < 60 && ndone < 4; k++) begin
            @(negedge clk);
            if (|done) begin
                ndone++;
                if (ndone == 4) req = '0;
            end
        end
        req = '0;
        check("alt_count", 32'(ndone), 32'd4);

        // Requester changes wdata/addr one cycle after grant.
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[2:0] = 3'd0; wdata[7:0] = 8'h11;
        sb.push_back('{0, 1'b1, 8'h00});
        @(posedge clk); #1;
        wdata[7:0] = 8'h22; addr[2:0] = 3'd5;
        wait_done(0);
        req[0] = 1'b0;
        check("chg_lat", 32'(lat), 32'd3);
        run_op(0, 1'b0, 3'd0, 8'h00, 8'h11);
        run_op(1, 1'b0, 3'd5, 8'h00, 8'h55);

        // Reset in the middle of a write aborts it without done.
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[2:0] = 3'd4; wdata[7:0] = 8'hEE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_hi_nib", 32'({sram_we, sram_ad}), 32'h1E);
        rst = 1'b1; req[0] = 1'b0;
        @(negedge clk);
        check("abort_sram_rst", 32'(sram_rst), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_we", 32'(sram_we), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_init_sram_rst", 32'(sram_rst), 32'd1);
        check("abort_rdata_rst", 32'(rdata), 32'd0);
        @(negedge clk);
        check("abort_idle_sram_rst", 32'(sram_rst), 32'd0);
        run_op(0, 1'b0, 3'd4, 8'h00, 8'h44);
        check_trace(1'b0, 3'd4, 8'h00);
        run_op(1, 1'b1, 3'd1, 8'h9B, 8'h00);
        check_trace(1'b1, 3'd1, 8'h9B);
        run_op(0, 1'b0, 3'd1, 8'h00, 8'h9B);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
